// File: rtl/variable_delay_mod.sv
// Programmable delay line: DIN is replayed on DOUT De cycles later through a circular FIFO.
// The delay is captured while RESET is high and held for the whole run that follows.
module variable_delay_mod #(
    parameter int MAX_DELAY_CNT_WIDTH = 7,
    parameter int WIDTH               = 48
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [MAX_DELAY_CNT_WIDTH-1:0] DELAY,
    input  logic [WIDTH-1:0]               DIN,
    output logic [WIDTH-1:0]               DOUT,
    output logic                           DELAY_READY,
    output logic                           DELAY_VALID,
    output logic [0:0]                     fsm_state,
    output logic                           fifo_full,
    output logic                           fifo_empty
);

    localparam int DW    = MAX_DELAY_CNT_WIDTH;
    localparam int DEPTH = 1 << DW;
    localparam int CW    = DW + 1;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    wr_ptr;
    logic [DW-1:0]    rd_ptr;
    logic [DW-1:0]    dl;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    de_m1;
    logic [0:0]       state;
    logic             armed;
    logic             pop;
    logic             bypass;
    logic             push_ok;
    logic             pop_ok;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CW'(DEPTH));
    assign fsm_state   = state;
    assign DELAY_READY = armed & ~RESET;

    // FIFO holds De-1 samples; the DOUT register is the last stage of the delay.
    // With De = 1 the FIFO stays empty and the push/pop pair passes DIN straight to DOUT.
    always_comb begin
        de_m1      = (dl == '0) ? '0 : ({1'b0, dl} - CW'(1));
        pop        = (state == RUN) || (count == de_m1);
        bypass     = pop && fifo_empty;
        push_ok    = !fifo_full && !bypass;
        pop_ok     = pop && !fifo_empty;
        count_next = count + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push_ok) begin
            mem[wr_ptr] <= DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            DOUT        <= '0;
            DELAY_VALID <= 1'b0;
            state       <= FILL;
            dl          <= DELAY;
            armed       <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + DW'(push_ok);
            rd_ptr <= rd_ptr + DW'(pop_ok);
            count  <= count_next;
            if (bypass) begin
                DOUT        <= DIN;
                DELAY_VALID <= 1'b1;
            end else if (pop_ok) begin
                DOUT        <= mem[rd_ptr];
                DELAY_VALID <= 1'b1;
            end
            if (state == FILL && count_next == de_m1) begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_variable_delay_mod.sv
// Directed bench for variable_delay_mod: counter-style DIN, DOUT checked against DIN - De each cycle.
module tb_variable_delay_mod;

    localparam int W = 48;

    logic         CLK;
    logic         RESET;
    logic [6:0]   DELAY;
    logic [W-1:0] DIN;
    logic [W-1:0] DOUT;
    logic         DELAY_READY;
    logic         DELAY_VALID;
    logic [0:0]   fsm_state;
    logic         fifo_full;
    logic         fifo_empty;

    int n_vec;
    int n_err;
    int cyc;

    variable_delay_mod #(.MAX_DELAY_CNT_WIDTH(7), .WIDTH(W)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .DELAY(DELAY),
        .DIN(DIN),
        .DOUT(DOUT),
        .DELAY_READY(DELAY_READY),
        .DELAY_VALID(DELAY_VALID),
        .fsm_state(fsm_state),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Hold reset for the given number of edges with DELAY = d, then release at cycle 0.
    task automatic do_reset(input int cycles, input logic [6:0] d);
        RESET = 1'b1;
        DELAY = d;
        repeat (cycles) @(posedge CLK);
        #1;
        check("rst_dout", DOUT, '0);
        check("rst_valid", {47'b0, DELAY_VALID}, 48'd0);
        check("rst_ready", {47'b0, DELAY_READY}, 48'd0);
        check("rst_empty", {47'b0, fifo_empty}, 48'd1);
        check("rst_full", {47'b0, fifo_full}, 48'd0);
        check("rst_state", {47'b0, fsm_state}, 48'd0);
        RESET = 1'b0;
        DELAY = 7'h55;
        cyc   = 0;
        #1;
        check("c0_ready", {47'b0, DELAY_READY}, 48'd1);
        check("c0_valid", {47'b0, DELAY_VALID}, 48'd0);
        check("c0_dout", DOUT, '0);
    endtask

    // Drive DIN = base + cycle for n cycles and check outputs against effective delay de.
    task automatic run(input int n, input int de, input logic [6:0] dly, input logic [W-1:0] base);
        logic exp_v;
        logic exp_s;
        for (int i = 0; i < n; i++) begin
            DIN   = base + W'(cyc);
            DELAY = dly;
            @(posedge CLK);
            #1;
            cyc++;
            exp_v = (cyc >= de);
            exp_s = (cyc >= ((de > 1) ? de - 1 : 1));
            check("valid", {47'b0, DELAY_VALID}, {47'b0, exp_v});
            check("dout", DOUT, exp_v ? base + W'(cyc - de) : '0);
            check("ready", {47'b0, DELAY_READY}, 48'd1);
            check("full", {47'b0, fifo_full}, 48'd0);
            check("state", {47'b0, fsm_state}, {47'b0, exp_s});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        RESET = 1'b1;
        DELAY = '0;
        DIN   = '0;

        // Basic delay of 4 after a long reset
        do_reset(10, 7'd4);
        run(200, 4, 7'd4, 48'h0000_0000_0000);

        // Delay 10, then re-arm with 7: no stale samples may leak through
        do_reset(3, 7'd10);
        run(200, 10, 7'd10, 48'hA5A5_0000_1000);
        do_reset(1, 7'd7);
        run(60, 7, 7'd7, 48'h0123_4567_0000);

        // DELAY input changed mid-run is ignored
        do_reset(2, 7'd4);
        run(40, 4, 7'd4, 48'hFFFF_FFFF_FFF0);
        run(40, 4, 7'd20, 48'hFFFF_FFFF_FFF0);

        // Zero behaves as one
        do_reset(2, 7'd0);
        run(30, 1, 7'd0, 48'h8000_0000_0000);

        // Delay 2 corner of the fill transition
        do_reset(1, 7'd2);
        run(20, 2, 7'd2, 48'h0000_1111_2222);

        // Maximum delay across several pointer wraps
        do_reset(2, 7'd127);
        run(450, 127, 7'd127, 48'h5555_AAAA_0000);

        // One-cycle reset in the middle of RUN, then refill with a new delay
        do_reset(2, 7'd5);
        run(30, 5, 7'd5, 48'h0F0F_0F0F_0000);
        do_reset(1, 7'd3);
        run(30, 3, 7'd3, 48'h7000_0000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
